shift_unit: RTL and testbench

- Parametrised, pipelined barrel shifter for the datapath: SLL, SRL, SRA, ROR and ROL on a WIDTH-bit operand.
- Successor to the fixed 16-bit combinational shifter. Adds configurable width, configurable pipeline depth, a valid/ready handshake with backpressure, a pass-through tag, and Z/N flags.
- Sits between the ALU operand mux and the writeback stage.

---
 rtl/shift_pkg.sv | 18 +
 rtl/shift_step.sv | 29 ++
 rtl/shift_unit.sv | 138 +++++++++++++
 tb/tb_shift_unit.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation codes and
// the helper that splits the log-steps into pipeline groups.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROR = 3'b011,
    OP_ROL = 3'b100
  } shift_op_e;

  // Log-steps per pipeline group; the last group may be shorter or empty.
  function automatic int steps_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational log-step of the barrel shifter: moves data by DIST bit
// positions when enabled. ROL never reaches here; it is rewritten to ROR at issue.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_e        op,
  input  logic             sign,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (en) begin
      case (op)
        OP_SLL:  result = data << DIST;
        OP_SRL:  result = data >> DIST;
        OP_SRA:  result = {{DIST{sign}}, data[WIDTH-1:DIST]};
        OP_ROR:  result = {data[DIST-1:0], data[WIDTH-1:DIST]};
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter with valid/ready flow control, a pass-through tag
// and zero/negative flags on the result.
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int STAGES  = 2,
  parameter  int TAG_W   = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_z,
  output logic               out_n
);

  localparam int SPS = steps_per_stage(SHAMT_W, STAGES);

  // Handshake: a transfer happens on an edge where valid && ready. A stage
  // accepts when it is empty or its downstream neighbour accepts this cycle,
  // so bubbles collapse and a full stage that cannot drain holds its contents.

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    shift_op_e          op;
    logic [SHAMT_W-1:0] shamt;
    logic               sign;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t              issue;
  stage_t              stage_q   [STAGES];
  stage_t              stage_nxt [STAGES];
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   up_valid;
  logic [STAGES:0]     ready;
  logic                z_q;
  logic                n_q;

  // ROL by s equals ROR by (WIDTH - s) mod WIDTH; the modulo is free in SHAMT_W bits.
  always_comb begin
    issue       = '0;
    issue.data  = in_data;
    issue.op    = shift_op_e'(in_op);
    issue.shamt = in_shamt;
    issue.sign  = in_data[WIDTH-1];
    issue.tag   = in_tag;
    if (in_op == OP_ROL) begin
      issue.op    = OP_ROR;
      issue.shamt = SHAMT_W'(0) - in_shamt;
    end
  end

  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    stage_t           src;
    logic [WIDTH-1:0] chain [SPS+1];

    if (g == 0) begin : g_head
      assign src         = issue;
      assign up_valid[g] = in_valid;
    end else begin : g_body
      assign src         = stage_q[g-1];
      assign up_valid[g] = valid_q[g-1];
    end

    assign chain[0] = src.data;

    for (genvar j = 0; j < SPS; j++) begin : g_step
      localparam int K = g * SPS + j;
      if (K < SHAMT_W) begin : g_real
        shift_step #(
          .WIDTH (WIDTH),
          .DIST  (1 << K)
        ) u_step (
          .data   (chain[j]),
          .op     (src.op),
          .sign   (src.sign),
          .en     (src.shamt[K]),
          .result (chain[j+1])
        );
      end else begin : g_pass
        assign chain[j+1] = chain[j];
      end
    end

    assign stage_nxt[g] = {chain[SPS], src.op, src.shamt, src.sign, src.tag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) begin
            stage_q[k] <= stage_nxt[k];
          end
        end
      end
      // Flags track the final-stage data register and only move when it loads.
      if (ready[STAGES-1] && up_valid[STAGES-1]) begin
        z_q <= (stage_nxt[STAGES-1].data == '0);
        n_q <= stage_nxt[STAGES-1].data[WIDTH-1];
      end
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = stage_q[STAGES-1].data;
  assign out_tag   = stage_q[STAGES-1].tag;
  assign out_z     = z_q;
  assign out_n     = n_q;

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: a 16-bit/2-stage instance under backpressure plus
// 32-bit instances with 1 and 5 stages fed from a shared input bus.
module tb_shift_unit;
  import shift_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        v16, rdy16, ordy16, ov16, z16, n16;
  logic [2:0]  op16;
  logic [15:0] d16, od16;
  logic [3:0]  s16, tag16, ot16;

  logic        v32;
  logic [2:0]  op32;
  logic [31:0] d32, oda, odb;
  logic [4:0]  s32;
  logic [3:0]  tag32, ota, otb;
  logic        rdya, ova, za, na, rdyb, ovb, zb, nb;

  shift_unit #(.WIDTH(16), .STAGES(2), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_op(op16),
    .in_data(d16), .in_shamt(s16), .in_tag(tag16), .out_valid(ov16),
    .out_ready(ordy16), .out_data(od16), .out_tag(ot16), .out_z(z16), .out_n(n16));

  shift_unit #(.WIDTH(32), .STAGES(1), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdya), .in_op(op32),
    .in_data(d32), .in_shamt(s32), .in_tag(tag32), .out_valid(ova),
    .out_ready(1'b1), .out_data(oda), .out_tag(ota), .out_z(za), .out_n(na));

  shift_unit #(.WIDTH(32), .STAGES(5), .TAG_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdyb), .in_op(op32),
    .in_data(d32), .in_shamt(s32), .in_tag(tag32), .out_valid(ovb),
    .out_ready(1'b1), .out_data(odb), .out_tag(otb), .out_z(zb), .out_n(nb));

  int n_checks = 0;
  int n_fail   = 0;
  int occ16    = 0;
  logic [21:0] q16[$];
  logic [37:0] qa[$];
  logic [37:0] qb[$];

  bit pat_on = 1'b0;
  int pat_idx = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  typedef struct {
    logic [2:0]  op;
    logic [15:0] d;
    logic [3:0]  s;
    logic [15:0] exp;
  } vec16_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp;
  } vec32_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference shifter built from whole-word shifts, independent of the log-step structure.
  function automatic logic [31:0] ref_shift(input int w, input logic [2:0] op,
                                            input logic [31:0] din, input int s);
    logic [31:0] mask, d, r;
    mask = (w == 32) ? 32'hffff_ffff : 32'h0000_ffff;
    d = din & mask;
    case (op)
      3'd0: r = d << s;
      3'd1: r = d >> s;
      3'd2: begin
        r = d >> s;
        if (d[w-1]) r = r | ~(mask >> s);
      end
      3'd3: r = (s == 0) ? d : ((d >> s) | (d << (w - s)));
      3'd4: r = (s == 0) ? d : ((d << s) | (d >> (w - s)));
      default: r = d;
    endcase
    return r & mask;
  endfunction

  function automatic logic [21:0] pack16(input logic [3:0] tag, input logic [15:0] d);
    return {tag, (d == 16'h0), d[15], d};
  endfunction

  function automatic logic [37:0] pack32(input logic [3:0] tag, input logic [31:0] d);
    return {tag, (d == 32'h0), d[31], d};
  endfunction

  // Output-ready pattern generator for the backpressure stream.
  always @(negedge clk) begin
    if (pat_on) begin
      ordy16 = pat[pat_idx % 6];
      pat_idx++;
    end
  end

  // Scoreboard and in_ready model for the 16-bit instance.
  always @(negedge clk) begin
    logic [21:0] e;
    #2;
    if (rst) begin
      occ16 = 0;
    end else begin
      check("in_ready16", rdy16, !(occ16 == 2 && !ordy16));
      if (ov16 && ordy16) begin
        if (q16.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out16_unexpected: got tag %0h data %0h expected none", ot16, od16);
        end else begin
          e = q16.pop_front();
          check("out16", {ot16, z16, n16, od16}, e);
        end
      end
      occ16 = occ16 + int'(v16 && rdy16) - int'(ov16 && ordy16);
    end
  end

  // Scoreboards for the 32-bit instances (out_ready tied high).
  always @(negedge clk) begin
    logic [37:0] e;
    #2;
    if (!rst) begin
      check("in_ready32", {rdya, rdyb}, 2'b11);
      if (ova) begin
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out32a_unexpected: got tag %0h data %0h expected none", ota, oda);
        end else begin
          e = qa.pop_front();
          check("out32a", {ota, za, na, oda}, e);
        end
      end
      if (ovb) begin
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out32b_unexpected: got tag %0h data %0h expected none", otb, odb);
        end else begin
          e = qb.pop_front();
          check("out32b", {otb, zb, nb, odb}, e);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send16(input logic [2:0] op, input logic [15:0] d, input logic [3:0] s,
                        input logic [3:0] tag, input logic [15:0] exp);
    int guard = 0;
    v16 = 1'b1; op16 = op; d16 = d; s16 = s; tag16 = tag;
    #1;
    while (!rdy16 && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    if (!rdy16) begin
      n_checks++; n_fail++;
      $display("FAIL send16_timeout: in_ready got 0 expected 1");
    end else begin
      q16.push_back(pack16(tag, exp));
    end
    @(negedge clk);
    v16 = 1'b0;
  endtask

  task automatic send32(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                        input logic [3:0] tag, input logic [31:0] exp);
    v32 = 1'b1; op32 = op; d32 = d; s32 = s; tag32 = tag;
    qa.push_back(pack32(tag, exp));
    qb.push_back(pack32(tag, exp));
    @(negedge clk);
    v32 = 1'b0;
  endtask

  task automatic wait_lat16(input int exp_lat);
    int lat = 1;
    while (!ov16 && lat < 50) begin
      @(negedge clk); lat++;
    end
    check("latency16", lat, exp_lat);
  endtask

  task automatic wait_lat32();
    int lat = 1;
    int la = 0;
    int lb = 0;
    while (lat < 50) begin
      if (ova && la == 0) la = lat;
      if (ovb && lb == 0) lb = lat;
      if (la != 0 && lb != 0) break;
      @(negedge clk); lat++;
    end
    check("latency32_s1", la, 1);
    check("latency32_s5", lb, 5);
  endtask

  task automatic drain();
    int guard = 0;
    while ((q16.size() + qa.size() + qb.size()) != 0 && guard < 300) begin
      @(negedge clk); guard++;
    end
    check("drain_left", q16.size() + qa.size() + qb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    vec16_t t16 [19];
    vec32_t t32 [6];
    logic [2:0]  rop;
    logic [15:0] rd;
    logic [31:0] rd32, rexp;
    logic [3:0]  rs;
    logic [4:0]  rs32;

    t16 = '{
      '{OP_SLL, 16'h0001, 4'd15, 16'h8000},
      '{OP_SLL, 16'h8000, 4'd1,  16'h0000},
      '{OP_SRA, 16'h8000, 4'd15, 16'hffff},
      '{OP_SRL, 16'h8000, 4'd15, 16'h0001},
      '{OP_SRA, 16'h4000, 4'd14, 16'h0001},
      '{OP_ROR, 16'h1234, 4'd4,  16'h4123},
      '{OP_ROL, 16'h1234, 4'd4,  16'h2341},
      '{OP_ROL, 16'h1234, 4'd0,  16'h1234},
      '{OP_ROR, 16'h1234, 4'd15, 16'h2468},
      '{3'b111, 16'h1234, 4'd5,  16'h1234},
      '{3'b101, 16'h1234, 4'd3,  16'h1234},
      '{OP_SRA, 16'hf000, 4'd0,  16'hf000},
      '{OP_SRL, 16'hffff, 4'd4,  16'h0fff},
      '{OP_SLL, 16'h00ff, 4'd8,  16'hff00},
      '{OP_SRA, 16'h8421, 4'd4,  16'hf842},
      '{OP_ROL, 16'h8001, 4'd1,  16'h0003},
      '{OP_SRL, 16'h1234, 4'd0,  16'h1234},
      '{OP_ROR, 16'h0001, 4'd1,  16'h8000},
      '{OP_SRA, 16'h7fff, 4'd15, 16'h0000}
    };
    t32 = '{
      '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000},
      '{OP_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456},
      '{OP_SRA, 32'h8000_0000, 5'd31, 32'hffff_ffff},
      '{OP_ROL, 32'h1234_5678, 5'd4,  32'h2345_6781},
      '{OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001},
      '{3'b110, 32'hdead_beef, 5'd7,  32'hdead_beef}
    };

    rst = 1'b1; ordy16 = 1'b1;
    v16 = 1'b0; op16 = '0; d16 = '0; s16 = '0; tag16 = '0;
    v32 = 1'b0; op32 = '0; d32 = '0; s32 = '0; tag32 = '0;
    repeat (3) @(negedge clk);
    check("reset_out16", {ov16, od16, ot16, z16, n16}, '0);
    check("reset_out32", {ova, ovb, oda, odb, ota, otb, za, zb, na, nb}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: first entry isolated for latency, remainder back-to-back.
    send16(t16[0].op, t16[0].d, t16[0].s, 4'd0, t16[0].exp);
    wait_lat16(2);
    drain();
    for (int i = 1; i < 19; i++) begin
      send16(t16[i].op, t16[i].d, t16[i].s, 4'(i), t16[i].exp);
    end
    drain();

    // Back-to-back stream under the 1,0,0,1,1,0 out_ready pattern.
    pat_on = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rd   = 16'($urandom);
      rs   = 4'($urandom_range(0, 15));
      rexp = ref_shift(16, rop, {16'h0, rd}, int'(rs));
      send16(rop, rd, rs, 4'(i), rexp[15:0]);
    end
    drain();
    pat_on = 1'b0;
    @(negedge clk);
    ordy16 = 1'b1;

    // Reset with two operations in flight, plus an input during the reset cycle.
    ordy16 = 1'b0;
    send16(OP_SLL, 16'h0001, 4'd1, 4'ha, 16'h0002);
    send16(OP_SRL, 16'h8000, 4'd1, 4'hb, 16'h4000);
    rst = 1'b1;
    v16 = 1'b1; op16 = OP_SLL; d16 = 16'h00f0; s16 = 4'd1; tag16 = 4'he;
    q16.delete();
    @(negedge clk);
    check("midreset_out16", {ov16, od16, ot16, z16, n16}, '0);
    rst = 1'b0; v16 = 1'b0; ordy16 = 1'b1;
    repeat (6) @(negedge clk);
    send16(OP_SRL, 16'h8000, 4'd15, 4'h9, 16'h0001);
    wait_lat16(2);
    drain();

    // 32-bit instances: directed entries with latency, then a random stream.
    for (int i = 0; i < 6; i++) begin
      send32(t32[i].op, t32[i].d, t32[i].s, 4'(i), t32[i].exp);
      wait_lat32();
      drain();
    end
    for (int i = 0; i < 10; i++) begin
      rop  = 3'($urandom_range(0, 7));
      rd32 = $urandom;
      rs32 = 5'($urandom_range(0, 31));
      send32(rop, rd32, rs32, 4'(i), ref_shift(32, rop, rd32, int'(rs32)));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
